// File: rtl/chicken_track.sv
// Chicken Cha Cha Cha board stage: tile-image ring, chicken positions, tail counts and target-tile search.
// Build option: define TAIL_STEAL_EN to transfer tails from chickens jumped over during a move.
`timescale 1ns/1ps

module chicken_track #(
  parameter int unsigned NUM_TILES     = 24,
  parameter int unsigned START_SPACING = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  N,
  input  logic [1:0]  T,
  input  logic        scan_req,
  input  logic        judge_valid,
  input  logic        go,
  input  logic        tile_we,
  input  logic [4:0]  tile_addr,
  input  logic [3:0]  tile_img,
  output logic [3:0]  position_data,
  output logic        pos_valid,
  output logic        busy,
  output logic        moved,
  output logic        stolen,
  output logic [4:0]  cur_pos,
  output logic [11:0] tails_all
);

  localparam int unsigned PW = 5;  // tile index
  localparam int unsigned IW = 4;  // tile image id
  localparam int unsigned CW = 3;  // tail count / player count
  localparam int unsigned NP = 4;  // player slots

`ifdef TAIL_STEAL_EN
  localparam bit STEAL_EN = 1'b1;
`else
  localparam bit STEAL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SEARCH, READY, MOVE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pos_q   [NP];
  logic [CW-1:0]   tails_q [NP];
  logic [IW-1:0]   img_q   [NUM_TILES];
  logic [PW-1:0]   cand_q;
  logic [NP-1:0]   skip_q;
  logic [1:0]      t_q;
  logic [CW-1:0]   cnt_q;

  logic [CW-1:0]   cnt_c;
  logic            scan_ok_c;
  logic [NP-1:0]   occ_c;
  logic [CW-1:0]   tails_nx_c [NP];
  logic            steal_c;
  logic [CW+1:0]   sum_c;
  logic            busy_d, pos_valid_d, moved_d, stolen_d;

  function automatic logic [PW-1:0] ring_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_TILES - 1)) ? '0 : p + PW'(1);
  endfunction

  // N=0 still means a two-player game
  always_comb begin
    cnt_c     = (N == 2'd0) ? CW'(2) : CW'(N) + CW'(1);
    scan_ok_c = (CW'(T) < cnt_c);
  end

  // Which active, non-moving chickens sit on the candidate tile
  always_comb begin
    occ_c = '0;
    for (int unsigned j = 0; j < NP; j++) begin
      occ_c[j] = (CW'(j) < cnt_q) && (2'(j) != t_q) && (pos_q[j] == cand_q);
    end
  end

  // Tails gathered from every jumped chicken, capped at 4
  always_comb begin
    tails_nx_c = tails_q;
    steal_c    = 1'b0;
    sum_c      = (CW+2)'(tails_q[t_q]);
    for (int unsigned j = 0; j < NP; j++) begin
      if (STEAL_EN && skip_q[j] && (tails_q[j] != '0)) begin
        sum_c         = sum_c + (CW+2)'(tails_q[j]);
        tails_nx_c[j] = '0;
        steal_c       = 1'b1;
      end
    end
    if (sum_c > (CW+2)'(4)) sum_c = (CW+2)'(4);
    tails_nx_c[t_q] = CW'(sum_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = 1'b0;
    pos_valid_d = 1'b0;
    moved_d     = 1'b0;
    stolen_d    = 1'b0;
    unique case (state_q)
      IDLE:    if (scan_req && scan_ok_c) state_d = SEARCH;
      SEARCH:  if (occ_c == '0) state_d = READY;
      READY:   if (judge_valid) state_d = go ? MOVE : IDLE;
      MOVE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE);
    pos_valid_d = (state_d == READY);
    moved_d     = (state_q == MOVE);
    stolen_d    = (state_q == MOVE) && steal_c;
  end

  // Board datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NP; i++) begin
        pos_q[i]   <= PW'((i * START_SPACING) % NUM_TILES);
        tails_q[i] <= CW'(1);
      end
      for (int unsigned i = 0; i < NUM_TILES; i++) img_q[i] <= '0;
      cand_q        <= '0;
      skip_q        <= '0;
      t_q           <= '0;
      cnt_q         <= CW'(2);
      position_data <= '0;
      pos_valid     <= 1'b0;
      busy          <= 1'b0;
      moved         <= 1'b0;
      stolen        <= 1'b0;
      cur_pos       <= '0;
    end else begin
      pos_valid <= pos_valid_d;
      busy      <= busy_d;
      moved     <= moved_d;
      stolen    <= stolen_d;
      unique case (state_q)
        IDLE: begin
          for (int unsigned i = 0; i < NUM_TILES; i++) begin
            if (tile_we && (tile_addr == PW'(i))) img_q[i] <= tile_img;
          end
          if (scan_req && scan_ok_c) begin
            t_q     <= T;
            cnt_q   <= cnt_c;
            cand_q  <= ring_inc(pos_q[T]);
            skip_q  <= '0;
            cur_pos <= pos_q[T];
          end
        end
        SEARCH: begin
          if (occ_c != '0) begin
            skip_q <= skip_q | occ_c;
            cand_q <= ring_inc(cand_q);
          end else begin
            position_data <= img_q[cand_q];
          end
        end
        READY: if (judge_valid) position_data <= '0;
        MOVE: begin
          pos_q[t_q] <= cand_q;
          cur_pos    <= cand_q;
          tails_q    <= tails_nx_c;
        end
        default: ;
      endcase
    end
  end

  assign tails_all = {tails_q[3], tails_q[2], tails_q[1], tails_q[0]};

endmodule

// File: tb/tb_chicken_track.sv
// Self-checking bench for chicken_track: turn-level reference model, per-cycle compare, directed pins plus random turns.
`timescale 1ns/1ps

module tb_chicken_track;

  localparam int NT = 24;
  localparam int SP = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  N = '0, T = '0;
  logic        scan_req = 1'b0, judge_valid = 1'b0, go = 1'b0, tile_we = 1'b0;
  logic [4:0]  tile_addr = '0;
  logic [3:0]  tile_img = '0;
  logic [3:0]  position_data;
  logic        pos_valid, busy, moved, stolen;
  logic [4:0]  cur_pos;
  logic [11:0] tails_all;

  chicken_track #(.NUM_TILES(NT), .START_SPACING(SP)) dut (
    .clk(clk), .rst(rst), .N(N), .T(T), .scan_req(scan_req), .judge_valid(judge_valid),
    .go(go), .tile_we(tile_we), .tile_addr(tile_addr), .tile_img(tile_img),
    .position_data(position_data), .pos_valid(pos_valid), .busy(busy), .moved(moved),
    .stolen(stolen), .cur_pos(cur_pos), .tails_all(tails_all)
  );

  always #5 clk = ~clk;

  // Reference model: board contents plus the pending turn
  int mpos [4];
  int mtl  [4];
  int mimg [NT];
  bit m_skip [4];
  bit m_busy, m_valid, m_moved, m_stolen, move_pend;
  int m_pdata, m_cur, srch_left, lat_t, m_target;
  bit chk_en = 1'b0;
  bit noise  = 1'b0;
  int n_pass = 0, n_total = 0;

  function automatic int m_tails_all();
    return mtl[0] + mtl[1] * 8 + mtl[2] * 64 + mtl[3] * 512;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mpos[i] = (i * SP) % NT;
      mtl[i] = 1;
      m_skip[i] = 1'b0;
    end
    for (int i = 0; i < NT; i++) mimg[i] = 0;
    m_busy = 0; m_valid = 0; m_moved = 0; m_stolen = 0; move_pend = 0;
    m_pdata = 0; m_cur = 0; srch_left = 0; lat_t = 0; m_target = 0;
  endtask

  // Advance the model across one clock edge given the inputs held before it
  task automatic model_update(input bit sr, input bit jv, input bit g, input bit we,
                              input int a, input int d, input int n, input int t);
    int cnt, cand, steps;
    bit hit;
    m_moved = 0;
    m_stolen = 0;
    if (move_pend) begin
      move_pend = 0;
      mpos[lat_t] = m_target;
      m_cur = m_target;
`ifdef TAIL_STEAL_EN
      for (int j = 0; j < 4; j++) begin
        if (m_skip[j] && mtl[j] > 0) begin
          mtl[lat_t] = (mtl[lat_t] + mtl[j] > 4) ? 4 : mtl[lat_t] + mtl[j];
          mtl[j] = 0;
          m_stolen = 1;
        end
      end
`endif
      m_moved = 1;
      m_busy = 0;
    end else if (srch_left > 0) begin
      srch_left--;
      if (srch_left == 0) begin
        m_valid = 1;
        m_pdata = mimg[m_target];
      end
    end else if (m_valid) begin
      if (jv) begin
        m_valid = 0;
        m_pdata = 0;
        if (g) move_pend = 1;
        else m_busy = 0;
      end
    end else begin
      if (we && a < NT) mimg[a] = d;
      if (sr) begin
        cnt = (n == 0) ? 2 : n + 1;
        if (t < cnt) begin
          lat_t = t;
          m_cur = mpos[t];
          for (int j = 0; j < 4; j++) m_skip[j] = 0;
          cand = (mpos[t] + 1) % NT;
          steps = 1;
          forever begin
            hit = 0;
            for (int j = 0; j < cnt; j++) begin
              if (j != t && mpos[j] == cand) begin
                m_skip[j] = 1;
                hit = 1;
              end
            end
            if (!hit) break;
            cand = (cand + 1) % NT;
            steps++;
          end
          m_target = cand;
          srch_left = steps;
          m_busy = 1;
        end
      end
    end
  endtask

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("pos_valid", pos_valid, m_valid);
      check("moved", moved, m_moved);
      check("stolen", stolen, m_stolen);
      check("position_data", position_data, m_pdata);
      check("cur_pos", cur_pos, m_cur);
      check("tails_all", tails_all, m_tails_all());
    end
  end

  task automatic step(input bit sr, input bit jv, input bit g, input bit we,
                      input int a, input int d, input int n, input int t);
    scan_req = sr; judge_valid = jv; go = g; tile_we = we;
    tile_addr = 5'(a); tile_img = 4'(d); N = 2'(n); T = 2'(t);
    @(posedge clk);
    #1;
    model_update(sr, jv, g, we, a, d, n, t);
    scan_req = 0; judge_valid = 0; go = 0; tile_we = 0;
  endtask

  // Idle cycle; with noise on, throws inputs that a busy block must ignore
  task automatic step_idle();
    bit we, sr, jv;
    we = noise && ($urandom_range(0, 3) == 0);
    sr = noise && m_busy && ($urandom_range(0, 3) == 0);
    jv = noise && (srch_left > 0 || move_pend) && ($urandom_range(0, 2) == 0);
    step(sr, jv, 1'($urandom), we, int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
  endtask

  task automatic turn(input int n, input int t, input bit g, input int dly, input bit wr);
    step(1, 0, 0, wr, int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), n, t);
    if (!m_busy) return;
    for (int k = 0; k < 8 && srch_left > 0; k++) step_idle();
    repeat (dly) step_idle();
    step(0, 1, g, 0, 0, 0, n, t);
    if (g) step_idle();
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    model_reset();
    check("rst_pos_valid", pos_valid, 0);
    check("rst_tails", tails_all, 12'o1111);
    check("rst_cur_pos", cur_pos, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  initial begin
    model_reset();
    #2 rst = 0;
    #1;
    check("init_cur_pos", cur_pos, 0);
    check("init_tails", tails_all, 12'o1111);
    check("init_pdata", position_data, 0);
    check("init_busy", busy, 0);
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1;

    // Tile images for the directed turns
    step(0, 0, 0, 1, 1, 5, 3, 0);
    step(0, 0, 0, 1, 7, 9, 3, 0);
    step(0, 0, 0, 1, 0, 4, 3, 0);
    step(0, 0, 0, 1, 30, 7, 3, 0);

    // Player 0 from 0 to tile 1
    step(1, 0, 0, 0, 0, 0, 3, 0);
    check("t1_busy", busy, 1);
    step_idle();
    check("t1_valid", pos_valid, 1);
    check("t1_pdata", position_data, 5);
    step(0, 1, 1, 0, 0, 0, 3, 0);
    step_idle();
    check("t1_moved", moved, 1);
    check("t1_cur_pos", cur_pos, 1);
    check("t1_stolen", stolen, 0);

    // Walk player 0 up to tile 5, then jump player 1 on tile 6
    repeat (4) turn(3, 0, 1, 0, 0);
    check("walk_cur_pos", cur_pos, 5);
    step(1, 0, 0, 0, 0, 0, 3, 0);
    step_idle();
    check("skip_valid_early", pos_valid, 0);
    step_idle();
    check("skip_pdata", position_data, 9);
    step(0, 1, 1, 0, 0, 0, 3, 0);
    step_idle();
    check("skip_cur_pos", cur_pos, 7);
`ifdef TAIL_STEAL_EN
    check("skip_tails", tails_all, 12'o1102);
    check("skip_stolen", stolen, 1);
`else
    check("skip_tails", tails_all, 12'o1111);
    check("skip_stolen", stolen, 0);
`endif

    // Player 3 to tile 23, then wrap to tile 0 and reject
    repeat (5) turn(3, 3, 1, 1, 0);
    check("wrap_start", cur_pos, 23);
    step(1, 0, 0, 0, 0, 0, 3, 3);
    step_idle();
    check("wrap_pdata", position_data, 4);
    step(0, 1, 0, 0, 0, 0, 3, 3);
    check("wrap_busy", busy, 0);
    step_idle();
    check("wrap_moved", moved, 0);
    check("wrap_cur_pos", cur_pos, 23);

    // Reset while awaiting judge; a late judge must be ignored
    step(1, 0, 0, 0, 0, 0, 3, 1);
    step_idle();
    step_idle();
    check("pre_rst_valid", pos_valid, 1);
    do_reset();
    step(0, 1, 1, 0, 0, 0, 3, 1);
    step_idle();
    check("late_judge_moved", moved, 0);
    check("late_judge_cur_pos", cur_pos, 0);

    // Randomized turns, including rejected T >= count and ignored inputs while busy
    noise = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      if ($urandom_range(0, 2) == 0) step_idle();
      turn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    step_idle();
    step_idle();

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
